mul_div_sequencer: RTL and testbench
====================================

// Module: mul_div_sequencer
// PURPOSE
//  Iterative MULTU/DIVU engine for the EX stage. Time-shares the EX-stage ALU
//  (add 3'b010, sub 3'b110) over WIDTH cycles and writes results to HI/LO.
//  Owns the ALU while busy and stalls conflicting EX instructions; idle -> ALU returns to pipeline.
// PARAMETERS
//  WIDTH   32   operand/result width; iteration count = WIDTH
//  CNT_W   6    iteration counter width, >= clog2(WIDTH+1)
// PORTS
//  clk          in   1      rising-edge clock; single clock domain
//  rst_n        in   1      asynchronous, active-low reset
//  start        in   1      request; sampled only in IDLE
//  op           in   2      00 MULTU, 01 DIVU, 10 MULT, 11 DIV (10/11 need SIGNED_MULDIV_EN)
//  rs_val       in   WIDTH  multiplicand / dividend
//  rt_val       in   WIDTH  multiplier / divisor
//  ex_uses_alu  in   1      EX-stage instruction needs the ALU this cycle
//  ex_reads_hilo in  1      EX-stage instruction is MFHI/MFLO
//  alu_res      in   WIDTH  shared ALU result
//  alu_own      out  1      1: EX ALU input mux selects alu_a/alu_b/alu_op below
//  alu_a        out  WIDTH  ALU operand 1
//  alu_b        out  WIDTH  ALU operand 2
//  alu_op       out  3      ALU operation code
//  busy         out  1      engine active (not IDLE)
//  done         out  1      one-cycle pulse, HI/LO valid
//  stall        out  1      busy & (ex_uses_alu | ex_reads_hilo)
//  hi, lo       out  WIDTH  architectural HI/LO
// BEHAVIOUR
//  Reset: state IDLE, counter 0; alu_own, busy, done, stall = 0; alu_a/alu_b = 0; alu_op = 3'b010;
//   hi = lo = 0. Reset mid-operation aborts immediately; partial results discarded.
//  States: IDLE -> (start & op valid) MUL | DIV | DZERO; MUL/DIV -> FIN after WIDTH iterations;
//   DZERO -> FIN; FIN -> IDLE. start in any non-IDLE state is ignored (no queueing).
//  Start accepted at edge 0: operands latched, counter = WIDTH, busy = 1 from next cycle.
//  MUL (shift-add, {hi,lo} = {0,rt}): per cycle, if lo[0], alu_a = hi, alu_b = rs, op = add;
//   carry = (alu_res < alu_a) unsigned; {hi,lo} <= {carry,sum,lo[WIDTH-1:1]}. If lo[0]=0: shift only,
//   alu_own still 1 with op = add, alu_b = 0.
//  DIV (restoring, rem = 0, quo = rs): shift {rem,quo} left 1; alu_a = rem', alu_b = rt, op = sub;
//   take when shifted-out bit = 1 or rem' >= rt: rem <= alu_res, quo[0] <= 1; else quo[0] <= 0.
//   End: hi = rem, lo = quo.
//  Divide by zero (rt = 0, DIVU/DIV): DZERO, no iterations; hi = rs, lo = all-ones; done 2 cycles after start.
//  Latency: start at edge 0 -> done high in cycle WIDTH+1 (33 for WIDTH=32); hi/lo update with done.
//  alu_own = 1 only in MUL/DIV; 0 in IDLE, DZERO, FIN. hi/lo hold old values until FIN.
//  stall combinational; deasserts in the cycle busy falls. done never coincides with accepting start.
//  op 10/11 without the macro: treated as MULTU/DIVU.
// CONFIGURATION
//  SIGNED_MULDIV_EN defined: MULT/DIV enabled. Operands negated via ALU sub (0 - x) in one
//   extra PRE cycle each when negative; results fixed up in POST cycles (product negated if signs
//   differ; quotient by sign XOR, remainder takes dividend sign). Adds up to 2 pre + 2 post cycles.
//  Undefined: no PRE/POST states; all ops unsigned; latency fixed at WIDTH+1.
// STRUCTURE
//  Package muldiv_pkg: state enum (IDLE, MUL, DIV, DZERO, FIN, PRE, POST), op codes, ALU constants
//   ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_SLT = 3'b111.
//  One sub-module: muldiv_iter_ctr (load/decrement CNT_W counter, terminal-count flag).
//  Operand mux toward the ALU sits in the EX stage, outside this block.
// TESTING
//  MULTU 7 x 6 -> hi = 0, lo = 42; done in cycle 33; alu_own = 1 for exactly 32 cycles.
//  MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001 (carry path).
//  DIVU 100 / 7 -> lo = 14, hi = 2; DIVU 5 / 0 -> hi = 5, lo = 0xFFFFFFFF, done after 2 cycles.
//  start while busy with different operands -> ignored, first result unchanged; ex_uses_alu = 1
//   while busy -> stall = 1; while idle -> stall = 0.
//  rst_n low at iteration 10 -> all outputs at reset values immediately; new start runs cleanly.
//  SIGNED_MULDIV_EN: MULT -3 x 5 -> {hi,lo} = -15; DIV -7 / 2 -> lo = -3, hi = -1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// The PRE/POST states are only reachable when SIGNED_MULDIV_EN is defined.
package muldiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_DIV   = 3'd2,
        S_DZERO = 3'd3,
        S_FIN   = 3'd4,
        S_PRE   = 3'd5,
        S_POST  = 3'd6
    } state_t;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/muldiv_iter_ctr.sv
// Iteration counter: loads the iteration count, counts down once per
// iteration and flags the last iteration (count == 1).
module muldiv_iter_ctr #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_tc = (r_count == CNT_W'(1));

endmodule

// File: rtl/mul_div_sequencer.sv
// Iterative MULTU/DIVU engine that borrows the EX-stage ALU while busy.
// Define SIGNED_MULDIV_EN to enable MULT/DIV via operand/result sign fix-up cycles.
module mul_div_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             ex_uses_alu,
    input  logic             ex_reads_hilo,
    input  logic [WIDTH-1:0] alu_res,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_rs, r_rt, r_acc_hi, r_acc_lo, r_hi, r_lo;
    logic             r_is_div;
    logic [WIDTH-1:0] w_acc_hi_next, w_acc_lo_next, w_hi_next, w_lo_next, w_rem_sh;
    logic             w_hilo_we, w_ctr_dec, w_tc, w_carry, w_take, w_accept, w_need_post;

    assign w_accept = (r_state == S_IDLE) && start;
    // Remainder after shifting {rem,quo} left by one; the bit shifted out is r_acc_hi[MSB].
    assign w_rem_sh = {r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};

`ifdef SIGNED_MULDIV_EN
    logic r_pre_a, r_pre_b, r_post_lo, r_post_hi;
    logic w_neg_rs, w_neg_rt;

    assign w_neg_rs    = op[1] & rs_val[WIDTH-1];
    assign w_neg_rt    = op[1] & rt_val[WIDTH-1];
    assign w_need_post = r_post_lo | r_post_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_a   <= 1'b0;
            r_pre_b   <= 1'b0;
            r_post_lo <= 1'b0;
            r_post_hi <= 1'b0;
        end else if (w_accept) begin
            r_pre_a   <= w_neg_rs;
            r_pre_b   <= w_neg_rt;
            r_post_lo <= w_neg_rs ^ w_neg_rt;
            r_post_hi <= op[0] ? w_neg_rs : (w_neg_rs ^ w_neg_rt);
        end else if (r_state == S_PRE) begin
            if (r_pre_a) r_pre_a <= 1'b0;
            else         r_pre_b <= 1'b0;
        end else if (r_state == S_POST) begin
            if (r_post_lo) r_post_lo <= 1'b0;
            else           r_post_hi <= 1'b0;
        end
    end
`else
    logic w_unused_op;
    assign w_unused_op = op[1];
    assign w_need_post = 1'b0;
`endif

    muldiv_iter_ctr #(.CNT_W(CNT_W)) u_iter_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_load_val (CNT_W'(WIDTH)),
        .i_dec      (w_ctr_dec),
        .o_tc       (w_tc)
    );

    always_comb begin
        w_state_next  = r_state;
        alu_own       = 1'b0;
        alu_a         = '0;
        alu_b         = '0;
        alu_op        = ALU_ADD;
        w_acc_hi_next = r_acc_hi;
        w_acc_lo_next = r_acc_lo;
        w_hilo_we     = 1'b0;
        w_hi_next     = r_acc_hi;
        w_lo_next     = r_acc_lo;
        w_ctr_dec     = 1'b0;
        w_carry       = 1'b0;
        w_take        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (op[0] && (rt_val == '0))
                        w_state_next = S_DZERO;
`ifdef SIGNED_MULDIV_EN
                    else if (w_neg_rs || w_neg_rt)
                        w_state_next = S_PRE;
`endif
                    else if (op[0])
                        w_state_next = S_DIV;
                    else
                        w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                alu_own       = 1'b1;
                alu_a         = r_acc_hi;
                alu_b         = r_acc_lo[0] ? r_rs : '0;
                w_carry       = (alu_res < r_acc_hi);
                w_acc_hi_next = {w_carry, alu_res[WIDTH-1:1]};
                w_acc_lo_next = {alu_res[0], r_acc_lo[WIDTH-1:1]};
                w_ctr_dec     = 1'b1;
            end
            S_DIV: begin
                alu_own       = 1'b1;
                alu_a         = w_rem_sh;
                alu_b         = r_rt;
                alu_op        = ALU_SUB;
                w_take        = r_acc_hi[WIDTH-1] | (w_rem_sh >= r_rt);
                w_acc_hi_next = w_take ? alu_res : w_rem_sh;
                w_acc_lo_next = {r_acc_lo[WIDTH-2:0], w_take};
                w_ctr_dec     = 1'b1;
            end
            S_DZERO: begin
                w_state_next = S_FIN;
                w_hilo_we    = 1'b1;
                w_hi_next    = r_rs;
                w_lo_next    = '1;
            end
            S_FIN: begin
                w_state_next = S_IDLE;
            end
`ifdef SIGNED_MULDIV_EN
            S_PRE: begin
                // Negate one operand per cycle (0 - x); the accumulator holds the
                // multiplier or dividend, so it is refreshed alongside.
                alu_own = 1'b1;
                alu_op  = ALU_SUB;
                alu_b   = r_pre_a ? r_rs : r_rt;
                if (r_pre_a ? r_is_div : !r_is_div)
                    w_acc_lo_next = alu_res;
                if (!(r_pre_a && r_pre_b))
                    w_state_next = r_is_div ? S_DIV : S_MUL;
            end
            S_POST: begin
                alu_own = 1'b1;
                alu_op  = ALU_SUB;
                if (r_post_lo) begin
                    alu_b         = r_acc_lo;
                    w_acc_lo_next = alu_res;
                end else begin
                    // 64-bit negate upper half: ~hi when the low half was nonzero, else 0 - hi.
                    alu_a         = (!r_is_div && (r_acc_lo != '0)) ? '1 : '0;
                    alu_b         = r_acc_hi;
                    w_acc_hi_next = alu_res;
                end
                if (!(r_post_lo && r_post_hi)) begin
                    w_state_next = S_FIN;
                    w_hilo_we    = 1'b1;
                    w_hi_next    = w_acc_hi_next;
                    w_lo_next    = w_acc_lo_next;
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_ctr_dec && w_tc) begin
            if (w_need_post) begin
                w_state_next = S_POST;
            end else begin
                w_state_next = S_FIN;
                w_hilo_we    = 1'b1;
                w_hi_next    = w_acc_hi_next;
                w_lo_next    = w_acc_lo_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rs     <= '0;
            r_rt     <= '0;
            r_is_div <= 1'b0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_rs     <= rs_val;
                r_rt     <= rt_val;
                r_is_div <= op[0];
                r_acc_hi <= '0;
                r_acc_lo <= op[0] ? rs_val : rt_val;
            end else begin
                r_acc_hi <= w_acc_hi_next;
                r_acc_lo <= w_acc_lo_next;
`ifdef SIGNED_MULDIV_EN
                if (r_state == S_PRE) begin
                    if (r_pre_a) r_rs <= alu_res;
                    else         r_rt <= alu_res;
                end
`endif
            end
            if (w_hilo_we) begin
                r_hi <= w_hi_next;
                r_lo <= w_lo_next;
            end
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_FIN);
    assign stall = busy & (ex_uses_alu | ex_reads_hilo);
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer (unsigned build) with a cycle-count
// reference model and per-cycle output comparison.
module tb_mul_div_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         ex_uses_alu = 1'b0;
    logic         ex_reads_hilo = 1'b0;
    logic [W-1:0] alu_res;
    logic         alu_own, busy, done, stall;
    logic [W-1:0] alu_a, alu_b, hi, lo;
    logic [2:0]   alu_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .op            (op),
        .rs_val        (rs_val),
        .rt_val        (rt_val),
        .ex_uses_alu   (ex_uses_alu),
        .ex_reads_hilo (ex_reads_hilo),
        .alu_res       (alu_res),
        .alu_own       (alu_own),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .busy          (busy),
        .done          (done),
        .stall         (stall),
        .hi            (hi),
        .lo            (lo)
    );

    // Shared EX-stage ALU
    assign alu_res = (alu_op == 3'b010) ? alu_a + alu_b :
                     (alu_op == 3'b110) ? alu_a - alu_b : '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining busy cycles plus the arithmetic result.
    int           m_cnt;
    logic         m_div, m_dz;
    logic [W-1:0] m_hi, m_lo, m_res_hi, m_res_lo;
    logic [63:0]  m_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_hi <= '0; m_lo <= '0; m_div <= 1'b0; m_dz <= 1'b0;
            m_res_hi <= '0; m_res_lo <= '0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_div <= op[0];
                m_dz  <= op[0] && (rt_val == 0);
                if (op[0] && rt_val == 0) begin
                    m_cnt <= 2; m_res_hi <= rs_val; m_res_lo <= '1;
                end else if (op[0]) begin
                    m_cnt <= W + 1; m_res_hi <= rs_val % rt_val; m_res_lo <= rs_val / rt_val;
                end else begin
                    m_prod = {32'b0, rs_val} * {32'b0, rt_val};
                    m_cnt <= W + 1; m_res_hi <= m_prod[63:32]; m_res_lo <= m_prod[31:0];
                end
            end
        end else begin
            if (m_cnt == 2) begin
                m_hi <= m_res_hi; m_lo <= m_res_lo;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_cnt > 0));
        chk("done", 64'(done), 64'(m_cnt == 1));
        chk("alu_own", 64'(alu_own), 64'((m_cnt > 1) && !m_dz));
        chk("stall", 64'(stall), 64'((m_cnt > 0) && (ex_uses_alu || ex_reads_hilo)));
        chk("hi", 64'(hi), 64'(m_hi));
        chk("lo", 64'(lo), 64'(m_lo));
        if (alu_own) begin
            chk("alu_op_own", 64'(alu_op), m_div ? 64'h6 : 64'h2);
        end else begin
            chk("alu_op_idle", 64'(alu_op), 64'h2);
            chk("alu_a_idle", 64'(alu_a), 64'h0);
            chk("alu_b_idle", 64'(alu_b), 64'h0);
        end
    end

    // probe: 0 none, 1 start while busy, 2 stall while busy, 3 stop at iteration 10
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int probe, output int done_cyc, output int own_cyc);
        @(posedge clk); #1;
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cyc = -1;
        own_cyc  = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk); #2;
            if (alu_own) own_cyc++;
            if (probe == 1 && i == 5) begin
                start = 1'b1; op = 2'b00; rs_val = 32'hDEAD; rt_val = 32'h3;
            end
            if (probe == 1 && i == 7) start = 1'b0;
            if (probe == 2 && i == 4) begin
                ex_uses_alu = 1'b1; #1;
                chk("stall_busy_uses", 64'(stall), 64'h1);
                ex_uses_alu = 1'b0; ex_reads_hilo = 1'b1; #1;
                chk("stall_busy_hilo", 64'(stall), 64'h1);
                ex_reads_hilo = 1'b0;
            end
            if (probe == 3 && i == 10) break;
            if (done) begin
                done_cyc = i;
                break;
            end
        end
        if (probe != 3) begin
            if (done_cyc < 0) begin
                checks++; errors++;
                $display("FAIL done_timeout actual=none required=done within 100 cycles");
            end
            $display("op=%0d rs=%h rt=%h hi=%h lo=%h done_cycle=%0d own_cycles=%0d",
                     o, a, b, hi, lo, done_cyc, own_cyc);
            @(posedge clk); #1;
        end
    endtask

    int dc, oc;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_alu_own", 64'(alu_own), 64'h0);
        chk("rst_alu_op", 64'(alu_op), 64'h2);
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        @(negedge clk); #2;
        rst_n = 1'b1;

        ex_uses_alu = 1'b1; #1;
        chk("stall_idle", 64'(stall), 64'h0);
        ex_uses_alu = 1'b0;

        run_op(2'b00, 32'd7, 32'd6, 2, dc, oc);
        chk("mul7x6_done_cycle", 64'(dc), 64'd33);
        chk("mul7x6_own_cycles", 64'(oc), 64'd32);
        chk("mul7x6_hi", 64'(hi), 64'h0);
        chk("mul7x6_lo", 64'(lo), 64'd42);

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, dc, oc);
        chk("mulmax_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("mulmax_lo", 64'(lo), 64'h0000_0001);

        run_op(2'b01, 32'd100, 32'd7, 1, dc, oc);
        chk("div100_7_lo", 64'(lo), 64'd14);
        chk("div100_7_hi", 64'(hi), 64'd2);
        chk("div100_7_done_cycle", 64'(dc), 64'd33);

        run_op(2'b01, 32'd5, 32'd0, 0, dc, oc);
        chk("div5_0_hi", 64'(hi), 64'd5);
        chk("div5_0_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("div5_0_done_cycle", 64'(dc), 64'd2);
        chk("div5_0_own_cycles", 64'(oc), 64'd0);

        run_op(2'b10, 32'd3, 32'd4, 0, dc, oc);
        chk("op10_as_multu_lo", 64'(lo), 64'd12);

        run_op(2'b11, 32'hFFFF_FFFF, 32'h10, 0, dc, oc);
        chk("op11_as_divu_lo", 64'(lo), 64'h0FFF_FFFF);
        chk("op11_as_divu_hi", 64'(hi), 64'hF);

        run_op(2'b00, 32'h8000_0000, 32'd2, 0, dc, oc);
        chk("mul_msb_hi", 64'(hi), 64'h1);
        chk("mul_msb_lo", 64'(lo), 64'h0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, dc, oc);
        chk("div_eq_lo", 64'(lo), 64'h1);
        chk("div_eq_hi", 64'(hi), 64'h0);

        run_op(2'b01, 32'd3, 32'd7, 0, dc, oc);
        chk("div_small_lo", 64'(lo), 64'h0);
        chk("div_small_hi", 64'(hi), 64'h3);

        run_op(2'b00, 32'd123, 32'd456, 3, dc, oc);
        ex_uses_alu = 1'b1;
        rst_n = 1'b0; #1;
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_done", 64'(done), 64'h0);
        chk("abort_stall", 64'(stall), 64'h0);
        chk("abort_alu_own", 64'(alu_own), 64'h0);
        chk("abort_alu_a", 64'(alu_a), 64'h0);
        chk("abort_alu_b", 64'(alu_b), 64'h0);
        chk("abort_alu_op", 64'(alu_op), 64'h2);
        chk("abort_hi", 64'(hi), 64'h0);
        chk("abort_lo", 64'(lo), 64'h0);
        $display("reset asserted mid-operation at iteration 10");
        ex_uses_alu = 1'b0;
        @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;

        run_op(2'b01, 32'd100, 32'd7, 0, dc, oc);
        chk("post_reset_lo", 64'(lo), 64'd14);
        chk("post_reset_hi", 64'(hi), 64'd2);
        chk("post_reset_done_cycle", 64'(dc), 64'd33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
